// File: rtl/tb_mem_latency_shim.sv
// Latency/backpressure shim between a req/gnt master and a 1-cycle SRAM.
// Responses are delayed by Latency cycles and buffered in a credit-limited FIFO.
module tb_mem_latency_shim #(
    parameter int unsigned AddrWidth      = 48,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned Latency        = 2,
    parameter int unsigned NumOutstanding = 4,
    parameter int unsigned StallPeriod    = 0
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               in_req_i,
    output logic                               in_gnt_o,
    input  logic                               in_we_i,
    input  logic [AddrWidth-1:0]               in_addr_i,
    input  logic [DataWidth-1:0]               in_wdata_i,
    input  logic [DataWidth/8-1:0]             in_be_i,
    output logic                               in_rvalid_o,
    input  logic                               in_rready_i,
    output logic [DataWidth-1:0]               in_rdata_o,
    output logic                               mem_req_o,
    output logic                               mem_we_o,
    output logic [AddrWidth-1:0]               mem_addr_o,
    output logic [DataWidth-1:0]               mem_wdata_o,
    output logic [DataWidth/8-1:0]             mem_be_o,
    input  logic [DataWidth-1:0]               mem_rdata_i,
    output logic [$clog2(NumOutstanding+1)-1:0] outstanding_o
);

    localparam int unsigned CntW   = $clog2(NumOutstanding + 1);
    localparam int unsigned PtrW   = $clog2(NumOutstanding);
    localparam int unsigned StallW = (StallPeriod > 1) ? $clog2(StallPeriod) : 1;

    localparam logic [CntW-1:0] CntMax = CntW'(NumOutstanding);
    localparam logic [CntW-1:0] CntOne = CntW'(1);
    localparam logic [PtrW:0]   PtrOne = (PtrW + 1)'(1);

    if (StallPeriod == 1) begin : g_bad_stall
        $error("StallPeriod of 1 would withhold every grant");
    end
    if (Latency < 1) begin : g_bad_latency
        $error("Latency must be at least 1");
    end

    logic stall;
    logic accept;
    logic resp_hs;

    if (StallPeriod >= 2) begin : g_stall
        localparam logic [StallW-1:0] StallLast = StallW'(StallPeriod - 1);
        logic [StallW-1:0] stall_cnt_q, stall_cnt_d;

        always_comb begin
            stall_cnt_d = (stall_cnt_q == StallLast) ? '0 : stall_cnt_q + StallW'(1);
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) stall_cnt_q <= '0;
            else         stall_cnt_q <= stall_cnt_d;
        end

        assign stall = (stall_cnt_q == StallLast);
    end else begin : g_no_stall
        assign stall = 1'b0;
    end

    // Credit counter: grant depends only on registered state.
    logic [CntW-1:0] cnt_q, cnt_d;

    assign in_gnt_o      = (cnt_q != CntMax) & ~stall;
    assign accept        = in_req_i & in_gnt_o;
    assign outstanding_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (accept && !resp_hs)      cnt_d = cnt_q + CntOne;
        else if (!accept && resp_hs) cnt_d = cnt_q - CntOne;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign mem_req_o   = accept;
    assign mem_we_o    = in_we_i;
    assign mem_addr_o  = in_addr_i;
    assign mem_wdata_o = in_wdata_i;
    assign mem_be_o    = in_be_i;

    // SRAM data is valid the cycle after acceptance; writes answer with zero.
    logic                 acc_q, acc_we_q;
    logic [DataWidth-1:0] s0_data;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q    <= 1'b0;
            acc_we_q <= 1'b0;
        end else begin
            acc_q    <= accept;
            acc_we_q <= accept & in_we_i;
        end
    end

    assign s0_data = acc_we_q ? '0 : mem_rdata_i;

    logic                 r_valid;
    logic [DataWidth-1:0] r_data;

    if (Latency > 1) begin : g_delay
        logic [Latency-2:0]   dv_q;
        logic [DataWidth-1:0] dd_q [Latency-1];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                dv_q <= '0;
            end else begin
                dv_q[0] <= acc_q;
                for (int unsigned i = 1; i < Latency - 1; i++) dv_q[i] <= dv_q[i-1];
            end
        end

        always_ff @(posedge clk_i) begin
            dd_q[0] <= s0_data;
            for (int unsigned i = 1; i < Latency - 1; i++) dd_q[i] <= dd_q[i-1];
        end

        assign r_valid = dv_q[Latency-2];
        assign r_data  = dd_q[Latency-2];
    end else begin : g_no_delay
        assign r_valid = acc_q;
        assign r_data  = s0_data;
    end

    // Fall-through FIFO; an arriving response bypasses storage when empty and taken.
    logic [PtrW:0]        wr_q, wr_d, rd_q, rd_d;
    logic [DataWidth-1:0] fifo_q [NumOutstanding];
    logic                 empty, push, fifo_pop;

    assign empty    = (wr_q == rd_q);
    assign push     = r_valid & ~(empty & in_rready_i);
    assign fifo_pop = ~empty & in_rready_i;

    assign in_rvalid_o = ~empty | r_valid;
    assign in_rdata_o  = empty ? r_data : fifo_q[rd_q[PtrW-1:0]];
    assign resp_hs     = in_rvalid_o & in_rready_i;

    always_comb begin
        wr_d = push     ? wr_q + PtrOne : wr_q;
        rd_d = fifo_pop ? rd_q + PtrOne : rd_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_q[PtrW-1:0]] <= r_data;
    end

endmodule

// File: tb/tb_tb_mem_latency_shim.sv
// Directed bench for tb_mem_latency_shim: default, Latency=1 and StallPeriod=3 instances.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_tb_mem_latency_shim;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Instance A: defaults (Latency 2, 4 credits, no stall)
    logic        req_a, gnt_a, we_a, rvalid_a, rready_a;
    logic [47:0] addr_a;
    logic [63:0] wdata_a, rdata_a;
    logic [7:0]  be_a;
    logic        mem_req_a, mem_we_a;
    logic [47:0] mem_addr_a;
    logic [63:0] mem_wdata_a, mem_rdata_a;
    logic [7:0]  mem_be_a;
    logic [2:0]  out_a;

    // Instance B: Latency 1
    logic        req_b, gnt_b, we_b, rvalid_b, rready_b;
    logic [47:0] addr_b;
    logic [63:0] wdata_b, rdata_b;
    logic [7:0]  be_b;
    logic        mem_req_b, mem_we_b;
    logic [47:0] mem_addr_b;
    logic [63:0] mem_wdata_b, mem_rdata_b;
    logic [7:0]  mem_be_b;
    logic [2:0]  out_b;

    // Instance C: StallPeriod 3
    logic        req_c, gnt_c, we_c, rvalid_c, rready_c;
    logic [47:0] addr_c;
    logic [63:0] wdata_c, rdata_c;
    logic [7:0]  be_c;
    logic        mem_req_c, mem_we_c;
    logic [47:0] mem_addr_c;
    logic [63:0] mem_wdata_c, mem_rdata_c;
    logic [7:0]  mem_be_c;
    logic [2:0]  out_c;

    assign mem_rdata_c = 64'h0;

    tb_mem_latency_shim dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .in_req_i(req_a), .in_gnt_o(gnt_a), .in_we_i(we_a), .in_addr_i(addr_a),
        .in_wdata_i(wdata_a), .in_be_i(be_a), .in_rvalid_o(rvalid_a),
        .in_rready_i(rready_a), .in_rdata_o(rdata_a),
        .mem_req_o(mem_req_a), .mem_we_o(mem_we_a), .mem_addr_o(mem_addr_a),
        .mem_wdata_o(mem_wdata_a), .mem_be_o(mem_be_a), .mem_rdata_i(mem_rdata_a),
        .outstanding_o(out_a)
    );

    tb_mem_latency_shim #(.Latency(1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .in_req_i(req_b), .in_gnt_o(gnt_b), .in_we_i(we_b), .in_addr_i(addr_b),
        .in_wdata_i(wdata_b), .in_be_i(be_b), .in_rvalid_o(rvalid_b),
        .in_rready_i(rready_b), .in_rdata_o(rdata_b),
        .mem_req_o(mem_req_b), .mem_we_o(mem_we_b), .mem_addr_o(mem_addr_b),
        .mem_wdata_o(mem_wdata_b), .mem_be_o(mem_be_b), .mem_rdata_i(mem_rdata_b),
        .outstanding_o(out_b)
    );

    tb_mem_latency_shim #(.StallPeriod(3)) dut_c (
        .clk_i(clk), .rst_ni(rst_n),
        .in_req_i(req_c), .in_gnt_o(gnt_c), .in_we_i(we_c), .in_addr_i(addr_c),
        .in_wdata_i(wdata_c), .in_be_i(be_c), .in_rvalid_o(rvalid_c),
        .in_rready_i(rready_c), .in_rdata_o(rdata_c),
        .mem_req_o(mem_req_c), .mem_we_o(mem_we_c), .mem_addr_o(mem_addr_c),
        .mem_wdata_o(mem_wdata_c), .mem_be_o(mem_be_c), .mem_rdata_i(mem_rdata_c),
        .outstanding_o(out_c)
    );

    // SRAM models: one-cycle read latency, 8-byte words indexed by addr[6:3].
    logic [63:0] sram_a [16];
    logic [63:0] sram_b [16];

    always @(posedge clk) begin
        if (mem_req_a) mem_rdata_a <= sram_a[mem_addr_a[6:3]];
    end

    always @(posedge clk) begin
        if (mem_req_b) begin
            if (mem_we_b) begin
                for (int i = 0; i < 8; i++)
                    if (mem_be_b[i]) sram_b[mem_addr_b[6:3]][i*8 +: 8] <= mem_wdata_b[i*8 +: 8];
                mem_rdata_b <= 64'hBAD0_BAD0_BAD0_BAD0;
            end else begin
                mem_rdata_b <= sram_b[mem_addr_b[6:3]];
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
        rready_a = 1'b1; rready_b = 1'b1; rready_c = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 16; k++) sram_a[k] = 64'hC0DE_0000_0000_0000 | 64'(k);
        sram_a[8] = 64'h0000_0000_DEAD_BEEF;
        we_a = 1'b0; addr_a = '0; wdata_a = '0; be_a = 8'hFF;
        we_b = 1'b0; addr_b = '0; wdata_b = '0; be_b = 8'hFF;
        we_c = 1'b0; addr_c = '0; wdata_c = '0; be_c = 8'hFF;

        // Reset state, with a request pending to exercise mem_req during reset
        rst_n = 1'b0;
        req_a = 1'b1; rready_a = 1'b1;
        #1;
        check_eq("rst_gnt", 64'(gnt_a), 64'd1);
        check_eq("rst_rvalid", 64'(rvalid_a), 64'd0);
        check_eq("rst_outstanding", 64'(out_a), 64'd0);
        check_eq("rst_mem_req", 64'(mem_req_a), 64'd1);

        // Single read, Latency 2
        do_reset();
        req_a = 1'b1; we_a = 1'b0; addr_a = 48'h40;
        #1;
        check_eq("rd_mem_req", 64'(mem_req_a), 64'd1);
        check_eq("rd_mem_addr", 64'(mem_addr_a), 64'h40);
        @(negedge clk);
        req_a = 1'b0; addr_a = 48'h7; we_a = 1'b1;
        #1;
        check_eq("rd_t1_rvalid", 64'(rvalid_a), 64'd0);
        check_eq("rd_t1_outstanding", 64'(out_a), 64'd1);
        check_eq("rd_t1_no_mem_req", 64'(mem_req_a), 64'd0);
        @(negedge clk);
        we_a = 1'b0;
        #1;
        check_eq("rd_t2_rvalid", 64'(rvalid_a), 64'd1);
        check_eq("rd_t2_rdata", rdata_a, 64'h0000_0000_DEAD_BEEF);
        @(negedge clk);
        #1;
        check_eq("rd_t3_outstanding", 64'(out_a), 64'd0);
        check_eq("rd_t3_rvalid", 64'(rvalid_a), 64'd0);

        // Latency 1: write then read of the same word
        do_reset();
        req_b = 1'b1; we_b = 1'b1; addr_b = 48'h08; wdata_b = 64'h1234_5678_9ABC_DEF0; be_b = 8'hFF;
        #1;
        check_eq("l1_wr_gnt", 64'(gnt_b), 64'd1);
        check_eq("l1_wr_mem_wdata", mem_wdata_b, 64'h1234_5678_9ABC_DEF0);
        check_eq("l1_wr_mem_be", 64'(mem_be_b), 64'hFF);
        @(negedge clk);
        we_b = 1'b0; wdata_b = '0;
        #1;
        check_eq("l1_wr_rvalid", 64'(rvalid_b), 64'd1);
        check_eq("l1_wr_rdata", rdata_b, 64'd0);
        check_eq("l1_rd_gnt", 64'(gnt_b), 64'd1);
        @(negedge clk);
        req_b = 1'b0;
        #1;
        check_eq("l1_rd_rvalid", 64'(rvalid_b), 64'd1);
        check_eq("l1_rd_rdata", rdata_b, 64'h1234_5678_9ABC_DEF0);
        check_eq("l1_rd_outstanding", 64'(out_b), 64'd1);
        @(negedge clk);
        #1;
        check_eq("l1_end_rvalid", 64'(rvalid_b), 64'd0);
        check_eq("l1_end_outstanding", 64'(out_b), 64'd0);

        // Credit exhaustion with rready low, then drain
        do_reset();
        rready_a = 1'b0; req_a = 1'b1; we_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            addr_a = 48'(k * 8);
            #1;
            check_eq($sformatf("cr_gnt%0d", k), 64'(gnt_a), 64'd1);
            @(negedge clk);
        end
        addr_a = 48'h20;
        #1;
        check_eq("cr_c4_gnt", 64'(gnt_a), 64'd0);
        check_eq("cr_c4_outstanding", 64'(out_a), 64'd4);
        check_eq("cr_c4_rvalid", 64'(rvalid_a), 64'd1);
        check_eq("cr_c4_rdata", rdata_a, 64'hC0DE_0000_0000_0000);
        @(negedge clk);
        #1;
        check_eq("cr_c5_gnt", 64'(gnt_a), 64'd0);
        check_eq("cr_c5_rdata", rdata_a, 64'hC0DE_0000_0000_0000);
        @(negedge clk);
        rready_a = 1'b1;
        #1;
        check_eq("cr_c6_gnt", 64'(gnt_a), 64'd0);
        check_eq("cr_c6_rdata", rdata_a, 64'hC0DE_0000_0000_0000);
        @(negedge clk);
        #1;
        check_eq("cr_c7_rdata", rdata_a, 64'hC0DE_0000_0000_0001);
        check_eq("cr_c7_outstanding", 64'(out_a), 64'd3);
        check_eq("cr_c7_gnt", 64'(gnt_a), 64'd1);
        @(negedge clk);
        req_a = 1'b0;
        #1;
        check_eq("cr_c8_rdata", rdata_a, 64'hC0DE_0000_0000_0002);
        check_eq("cr_c8_outstanding", 64'(out_a), 64'd3);
        @(negedge clk);
        #1;
        check_eq("cr_c9_rdata", rdata_a, 64'hC0DE_0000_0000_0003);
        check_eq("cr_c9_outstanding", 64'(out_a), 64'd2);
        @(negedge clk);
        #1;
        check_eq("cr_c10_rdata", rdata_a, 64'hC0DE_0000_0000_0004);
        check_eq("cr_c10_outstanding", 64'(out_a), 64'd1);
        @(negedge clk);
        #1;
        check_eq("cr_c11_rvalid", 64'(rvalid_a), 64'd0);
        check_eq("cr_c11_outstanding", 64'(out_a), 64'd0);

        // Stall pattern 1,1,0 from reset release
        do_reset();
        req_c = 1'b1; rready_c = 1'b1; addr_c = 48'h10;
        begin
            logic [5:0] pat;
            pat = 6'b011011;
            for (int k = 0; k < 6; k++) begin
                #1;
                check_eq($sformatf("stall_gnt%0d", k), 64'(gnt_c), 64'(pat[k]));
                @(negedge clk);
            end
        end
        req_c = 1'b0;

        // Reset mid-operation with 3 outstanding
        do_reset();
        rready_a = 1'b0; req_a = 1'b1; we_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            addr_a = 48'(k * 8);
            @(negedge clk);
        end
        req_a = 1'b0;
        #1;
        check_eq("mid_pre_outstanding", 64'(out_a), 64'd3);
        check_eq("mid_pre_rvalid", 64'(rvalid_a), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_rvalid", 64'(rvalid_a), 64'd0);
        check_eq("mid_rst_outstanding", 64'(out_a), 64'd0);
        check_eq("mid_rst_gnt", 64'(gnt_a), 64'd1);
        @(negedge clk);
        rst_n = 1'b1; rready_a = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            check_eq($sformatf("mid_post_rvalid%0d", k), 64'(rvalid_a), 64'd0);
            @(negedge clk);
        end
        #1;
        check_eq("mid_post_outstanding", 64'(out_a), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tb_mem_latency_shim.md
TB_MEM_LATENCY_SHIM -- requirements
Module: tb_mem_latency_shim

Interface
REQ-001 SHALL have parameter AddrWidth, default 48: request address width.
REQ-002 SHALL have parameter DataWidth, default 64: data width, multiple of 8.
REQ-003 SHALL have parameter Latency, default 2: grant-to-response latency in cycles, legal range >=1.
REQ-004 SHALL have parameter NumOutstanding, default 4: response buffer depth and credit limit, power of 2, >=2.
REQ-005 SHALL have parameter StallPeriod, default 0: 0 = never stall; N>=2 = withhold grant one cycle in every N; 1 is illegal (elaboration assertion).
REQ-006 SHALL have port clk_i  input  1: single clock, all state on rising edge.
REQ-007 SHALL have port rst_ni  input  1: reset, asynchronous, active-low.
REQ-008 SHALL have port in_req_i  input  1: upstream request valid.
REQ-009 SHALL have port in_gnt_o  output  1: request accepted when in_req_i & in_gnt_o.
REQ-010 SHALL have port in_we_i  input  1: write enable.
REQ-011 SHALL have port in_addr_i  input  AddrWidth: byte address.
REQ-012 SHALL have port in_wdata_i  input  DataWidth: write data.
REQ-013 SHALL have port in_be_i  input  DataWidth/8: byte enables.
REQ-014 SHALL have port in_rvalid_o  output  1: response valid.
REQ-015 SHALL have port in_rready_i  input  1: response accepted when in_rvalid_o & in_rready_i.
REQ-016 SHALL have port in_rdata_o  output  DataWidth: response data.
REQ-017 SHALL have ports mem_req_o, mem_we_o (1), mem_addr_o (AddrWidth), mem_wdata_o (DataWidth), mem_be_o (DataWidth/8) as outputs: SRAM request, SRAM read data valid exactly one cycle after mem_req_o.
REQ-018 SHALL have port mem_rdata_i  input  DataWidth: SRAM read data.
REQ-019 SHALL have port outstanding_o  output  clog2(NumOutstanding+1): accepted-but-unreturned request count.

Function
REQ-020 SHALL drive mem_req_o = in_req_i & in_gnt_o combinationally; mem_we/addr/wdata/be SHALL pass through unmodified.
REQ-021 SHALL drive in_gnt_o = (outstanding count != NumOutstanding) & ~stall, depending on registered state only (no same-cycle path from in_rready_i).
REQ-022 SHALL keep a free-running stall counter 0..StallPeriod-1 (wrap to 0); stall = 1 when counter == StallPeriod-1; stall constant 0 when StallPeriod == 0.
REQ-023 SHALL produce exactly one response per accepted request, reads and writes alike, in acceptance order.
REQ-024 SHALL return mem_rdata_i sampled at T+1 for a read accepted at cycle T; SHALL return all-zero data for a write.
REQ-025 SHALL delay responses through Latency-1 register stages (valid, data) after T+1, then into a fall-through FIFO of depth NumOutstanding.
REQ-026 SHALL present the response at in_rvalid_o in cycle T+Latency when the FIFO is empty; bypass SHALL add no cycle.
REQ-027 SHALL hold in_rvalid_o and in_rdata_o stable while in_rvalid_o & ~in_rready_i.
REQ-028 SHALL increment the count on accept, decrement on response handshake, leave it unchanged when both occur in the same cycle.
REQ-029 SHALL never overflow the FIFO: in-flight plus buffered entries are bounded by the count.
REQ-030 SHALL accept back-to-back requests every cycle while credits remain and no stall applies.
REQ-031 SHALL ignore in_we_i/in_addr_i/in_wdata_i/in_be_i when no handshake occurs.

Reset
REQ-032 SHALL, while rst_ni low, clear count, stall counter, delay-stage valids and FIFO pointers asynchronously.
REQ-033 SHALL drive in_rvalid_o = 0, outstanding_o = 0, in_gnt_o = 1 in reset state; mem_req_o follows REQ-020.
REQ-034 SHALL discard all in-flight and buffered responses on reset mid-operation; no response SHALL appear after reset release without a new request.

Verification
REQ-035 Latency=2, rready=1: read 0x40 at T (SRAM word 0xDEAD_BEEF) -> mem_req_o at T, in_rvalid_o at T+2 with 0xDEAD_BEEF, count back to 0 at T+3.
REQ-036 Latency=1: write at T then read same address at T+1 -> write response data 0 at T+1, read response with written data at T+2, order preserved.
REQ-037 NumOutstanding=4, rready=0, req held high -> 4 grants, in_gnt_o low from 5th cycle, outstanding_o=4; raise rready -> 4 responses in order, one per cycle, grants resume one cycle after first pop.
REQ-038 StallPeriod=3, req continuously high, rready=1 -> in_gnt_o pattern 1,1,0 repeating from reset release.
REQ-039 count=4, pop and FIFO full -> in_gnt_o stays 0 that cycle, count 3 next cycle, then grant.
REQ-040 Reset asserted with 3 outstanding -> in_rvalid_o 0 immediately, outstanding_o 0, no responses after release until new request.
